// File: rtl/s_memory_shuffle.sv
// RC4 key-scheduling shuffle over an external 256-byte S memory with 1-cycle read latency.
// Each iteration reads S[i] and S[j], then writes them back swapped (6 cycles per i).
module s_memory_shuffle (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic        finish,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wren,
  input  logic [7:0]  q
);

  typedef enum logic [2:0] {
    IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  i, j, s_i, s_j;
  logic [1:0]  key_idx;
  logic [7:0]  key_byte;

  // key_idx tracks i mod 3 as a wrapping counter
  always_comb begin
    case (key_idx)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      default: key_byte = secret_key[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ_I;
      READ_I:  state_nxt = WAIT_I;
      WAIT_I:  state_nxt = READ_J;
      READ_J:  state_nxt = WAIT_J;
      WAIT_J:  state_nxt = WRITE_I;
      WRITE_I: state_nxt = WRITE_J;
      WRITE_J: state_nxt = (i == 8'd255) ? DONE : READ_I;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i       <= 8'd0;
      j       <= 8'd0;
      s_i     <= 8'd0;
      s_j     <= 8'd0;
      key_idx <= 2'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          i       <= 8'd0;
          j       <= 8'd0;
          key_idx <= 2'd0;
        end
        WAIT_I: begin
          s_i <= q;
          j   <= j + q + key_byte;
        end
        WAIT_J: s_j <= q;
        WRITE_J: if (i != 8'd255) begin
          i       <= i + 8'd1;
          key_idx <= (key_idx == 2'd2) ? 2'd0 : key_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state alone, so reset clears them without a clock
  always_comb begin
    address = 8'd0;
    data    = 8'd0;
    wren    = 1'b0;
    finish  = 1'b0;
    case (state)
      READ_I, WAIT_I: address = i;
      READ_J, WAIT_J: address = j;
      WRITE_I: begin
        address = i;
        data    = s_j;
        wren    = 1'b1;
      end
      WRITE_J: begin
        address = j;
        data    = s_i;
        wren    = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_s_memory_shuffle.sv
// Bench for s_memory_shuffle: synchronous S memory model plus a software RC4 KSA reference.
module tb_s_memory_shuffle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = 24'd0;
  logic        finish;
  logic [7:0]  address, data;
  logic        wren;
  logic [7:0]  q = 8'd0;

  logic [7:0]  mem [256];
  logic [7:0]  init_s [256];
  logic        load = 1'b0;

  logic [7:0]  ref_s [256];
  logic [7:0]  exp_j [256];
  logic [7:0]  wd_i [256];
  logic [7:0]  wd_j [256];

  int vectors = 0;
  int errors  = 0;

  s_memory_shuffle dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .finish(finish), .address(address), .data(data), .wren(wren), .q(q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_s[k];
    end else if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < 256; k++) init_s[k] = k[7:0];
  endtask

  task automatic fill_random();
    logic [7:0] t;
    int r;
    fill_identity();
    for (int k = 255; k > 0; k--) begin
      r = $urandom_range(k, 0);
      t = init_s[k]; init_s[k] = init_s[r]; init_s[r] = t;
    end
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic build_model(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] jj, t;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) ref_s[k] = init_s[k];
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + ref_s[n] + kb[n % 3];
      exp_j[n] = jj;
      wd_i[n]  = ref_s[jj];
      wd_j[n]  = ref_s[n];
      t = ref_s[n]; ref_s[n] = ref_s[jj]; ref_s[jj] = t;
    end
  endtask

  // mode 0: plain run, 1: start toggled mid-run, 2: reset asserted in WRITE_I of i=100
  task automatic run_shuffle(input logic [23:0] key, input int mode);
    int wcount;
    build_model(key);
    load_mem();
    secret_key = key;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    wcount = 0;
    for (int c = 0; c < 1536; c++) begin
      int it, off;
      #1;
      it = c / 6; off = c % 6;
      if (wren) wcount++;
      case (off)
        0: begin
          check($sformatf("rd_i_addr i=%0d", it), address, it);
          check("rd_i_wren", wren, 0);
        end
        2: begin
          check($sformatf("rd_j_addr i=%0d", it), address, exp_j[it]);
          check("rd_j_wren", wren, 0);
        end
        4: begin
          check($sformatf("wr_i_addr i=%0d", it), address, it);
          check($sformatf("wr_i_data i=%0d", it), data, wd_i[it]);
          check("wr_i_wren", wren, 1);
        end
        5: begin
          check($sformatf("wr_j_addr i=%0d", it), address, exp_j[it]);
          check($sformatf("wr_j_data i=%0d", it), data, wd_j[it]);
          check("wr_j_wren", wren, 1);
        end
        default: check("wait_wren", wren, 0);
      endcase
      if (c == 1535) check("finish_early", finish, 0);
      if (mode == 1 && c == 500) start = 1'b0;
      if (mode == 1 && c == 700) start = 1'b1;
      if (mode == 2 && c == 604) begin
        check("abort_in_write_i", wren, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_wren", wren, 0);
        check("abort_finish", finish, 0);
        check("abort_addr", address, 0);
        return;
      end
      @(posedge clk);
    end
    #1;
    check("finish_rise", finish, 1);
    check("done_wren", wren, 0);
    check("done_addr", address, 0);
    check("wren_pulses", wcount, 512);
    for (int k = 0; k < 256; k++) check($sformatf("final_s[%0d]", k), mem[k], ref_s[k]);
    repeat (3) begin
      @(posedge clk); #1;
      check("finish_hold", finish, 1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("finish_drop", finish, 0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_finish", finish, 0);
    check("rst_wren", wren, 0);
    check("rst_addr", address, 0);
    check("rst_data", data, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_addr", address, 0);
      check("idle_wren", wren, 0);
    end

    fill_identity(); run_shuffle(24'h010203, 0);
    fill_identity(); run_shuffle(24'h000000, 0);
    fill_identity(); run_shuffle(24'h000249, 0);
    fill_random();   run_shuffle(24'($urandom), 0);
    fill_identity(); run_shuffle(24'($urandom), 1);

    fill_identity(); run_shuffle(24'($urandom), 2);
    start = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle_addr", address, 0);
      check("post_rst_idle_wren", wren, 0);
      check("post_rst_idle_finish", finish, 0);
    end
    fill_identity(); run_shuffle(24'h000249, 0);
    fill_random();   run_shuffle(24'($urandom), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/s_memory_shuffle.md
S_MEMORY_SHUFFLE -- requirements
Module: s_memory_shuffle

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have port start  input  1  level request to run the key-scheduling shuffle.
REQ-004 The block SHALL have port secret_key  input  24  RC4 key, key[0]=secret_key[23:16], key[1]=[15:8], key[2]=[7:0].
REQ-005 The block SHALL have port finish  output  1  shuffle complete.
REQ-006 The block SHALL have port address  output  8  S memory address.
REQ-007 The block SHALL have port data  output  8  S memory write data.
REQ-008 The block SHALL have port wren  output  1  S memory write enable.
REQ-009 The block SHALL have port q  input  8  S memory read data, valid in the cycle after the address is presented (1-cycle read latency).

Function
REQ-010 The block SHALL perform, for i=0..255: j = (j + S[i] + key[i mod 3]) mod 256, then swap S[i] and S[j], with j=0 and i=0 at start.
REQ-011 The block SHALL use a state machine with states IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J and DONE.
REQ-012 In IDLE, the block SHALL drive address=0, data=0, wren=0 and finish=0; when start=1 it SHALL clear i and j and go to READ_I.
REQ-013 In READ_I, the block SHALL drive address=i with wren=0, then go to WAIT_I.
REQ-014 In WAIT_I, the block SHALL drive address=i with wren=0; at the clock edge it SHALL capture s_i<=q and update j<=j+q+key[i mod 3] (8-bit wrap, carries discarded), then go to READ_J.
REQ-015 In READ_J, the block SHALL drive address=j (the updated value) with wren=0, then go to WAIT_J.
REQ-016 In WAIT_J, the block SHALL drive address=j with wren=0; at the clock edge it SHALL capture s_j<=q, then go to WRITE_I.
REQ-017 In WRITE_I, the block SHALL drive address=i, data=s_j and wren=1, then go to WRITE_J.
REQ-018 In WRITE_J, the block SHALL drive address=j, data=s_i and wren=1; if i=255 it SHALL go to DONE, otherwise it SHALL increment i and go to READ_I.
REQ-019 Each iteration SHALL take exactly 6 cycles, and a full shuffle SHALL take 1536 cycles from the first READ_I to DONE.
REQ-020 In the case i=j, both writes SHALL target the same address with value S[i], leaving S[i] unchanged.
REQ-021 wren SHALL be 1 only in WRITE_I and WRITE_J, and the block SHALL never assert it in any other state.
REQ-022 In DONE, the block SHALL drive finish=1, wren=0 and address=0, and SHALL stay in DONE while start=1.
REQ-023 In DONE, when start=0 the block SHALL return to IDLE, so that finish deasserts on the next cycle.
REQ-024 A change of start outside IDLE and DONE SHALL be ignored, and the run SHALL continue to completion.
REQ-025 The block SHALL sample secret_key in WAIT_I of each iteration, and the key SHALL be held stable during a run.
REQ-026 The key index SHALL be i mod 3, implemented as a counter that wraps 0,1,2 and is cleared on start; the block SHALL NOT use a divider.

Reset
REQ-027 Asserting reset SHALL, asynchronously, force state=IDLE, i=0, j=0, s_i=0, s_j=0, finish=0, wren=0, address=0 and data=0.
REQ-028 On reset during a run, the block SHALL abort the shuffle immediately; S memory content is left partially shuffled and is not restored, and the next start SHALL begin again from i=0, j=0.
REQ-029 After reset is released, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-030 Identity S (S[n]=n) with key 0x010203 and start=1: the first iteration reads address 0 then 1, writes address 0 data 0x01 with wren=1, then writes address 1 data 0x00 with wren=1.
REQ-031 Identity S with key 0x000000: i=0 gives j=0, so two writes go to address 0 with data 0 and S[0] stays 0; i=1 gives j=1, with writes to address 1 data 1, twice.
REQ-032 Start is sampled at edge E0: READ_I occurs in the cycle after E0, and finish is high exactly 1536 cycles later and stays high while start=1; after start drops, finish is 0 one cycle later.
REQ-033 Reset asserted at i=100 during WRITE_I: wren and finish go to 0 immediately without waiting for a clock; after release and start=1, the first read is at address 0.
REQ-034 Full run of key 0x000249 on identity S: the final S memory contents match the software RC4 KSA reference model byte-for-byte, and wren pulses exactly 512 times.
REQ-035 start toggled 1->0->1 mid-run: no effect on the address/wren sequence, and finish still rises at cycle 1536.
